// File: rtl/apb_rr_arb.sv
// apb_rr_arb: round-robin arbiter and APB transfer sequencer in front of si.
// Grants one of N masters at a time, drives SETUP/ACCESS phases toward si and
// returns read data plus a one-cycle done pulse when si signals pready_s.
//
// Optional build macro: APB_ARB_TIMEOUT_EN
//   defined   -> ACCESS phase aborts after TO_CYCLES cycles with err=1, rdata=0
//   undefined -> no timeout counter, err is always 0, ACCESS waits for pready_s
//
// Ports:
//   clk, rst_b               clock (rising edge), synchronous active-low reset
//   req[N]                   per-master request, held until that master's done
//   pwrite_m/paddr_m/pwdata_m/way_en_m   per-master transfer fields (packed)
//   gnt[N]                   one-hot grant, high for the whole transfer
//   done[N]                  one-cycle completion pulse to the granted master
//   rdata, err               read data / timeout flag, valid with done
//   psel_arb, penable_arb, pwrite_mi, paddr_mi, pwdata_mi, way_en   bus to si
//   prdata_s, pready_s       read data / ready from si
module apb_rr_arb #(
    parameter int unsigned N         = 3,
    parameter int unsigned AW        = 16,
    parameter int unsigned DW        = 32,
    parameter int unsigned WW        = 3,
    parameter int unsigned TO_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    pwrite_m,
    input  logic [N*AW-1:0] paddr_m,
    input  logic [N*DW-1:0] pwdata_m,
    input  logic [N*WW-1:0] way_en_m,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    done,
    output logic [DW-1:0]   rdata,
    output logic            err,
    output logic            psel_arb,
    output logic            penable_arb,
    output logic            pwrite_mi,
    output logic [AW-1:0]   paddr_mi,
    output logic [DW-1:0]   pwdata_mi,
    output logic [WW-1:0]   way_en,
    input  logic [DW-1:0]   prdata_s,
    input  logic            pready_s
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] last;
    logic [IW-1:0] gidx;
    logic [IW-1:0] pick_idx;
    logic          pick_valid;
    logic [N-1:0]  elig;
    logic          to_hit;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TO_CYCLES + 1);
    logic [CW-1:0] to_cnt;

    // Counter holds the number of completed ACCESS cycles minus one at each edge.
    assign to_hit = (to_cnt == CW'(TO_CYCLES - 1));
`else
    assign to_hit = 1'b0;
`endif

    // Round-robin pick: first eligible master searching upward from last+1.
    // Descending loop so the lowest offset wins by being assigned last.
    always_comb begin
        elig       = req & ~done;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = int'(N); k >= 1; k--) begin
            if (elig[IW'((int'(last) + k) % int'(N))]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'((int'(last) + k) % int'(N));
            end
        end
    end

    // Transfer sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state       <= IDLE;
            last        <= IW'(N - 1);
            gidx        <= '0;
            gnt         <= '0;
            done        <= '0;
            rdata       <= '0;
            err         <= 1'b0;
            psel_arb    <= 1'b0;
            penable_arb <= 1'b0;
            pwrite_mi   <= 1'b0;
            paddr_mi    <= '0;
            pwdata_mi   <= '0;
            way_en      <= '0;
`ifdef APB_ARB_TIMEOUT_EN
            to_cnt      <= '0;
`endif
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gidx        <= pick_idx;
                        gnt         <= N'(1) << pick_idx;
                        psel_arb    <= 1'b1;
                        penable_arb <= 1'b0;
                        pwrite_mi   <= pwrite_m[pick_idx];
                        paddr_mi    <= paddr_m[int'(pick_idx) * AW +: AW];
                        pwdata_mi   <= pwdata_m[int'(pick_idx) * DW +: DW];
                        way_en      <= way_en_m[int'(pick_idx) * WW +: WW];
                        state       <= SETUP;
                    end else begin
                        pwrite_mi <= 1'b0;
                        paddr_mi  <= '0;
                        pwdata_mi <= '0;
                        way_en    <= '0;
                    end
                end
                SETUP: begin
                    penable_arb <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
                    to_cnt      <= '0;
`endif
                    state       <= ACCESS;
                end
                ACCESS: begin
                    // A same-edge pready_s takes precedence over the timeout.
                    if (pready_s || to_hit) begin
                        psel_arb    <= 1'b0;
                        penable_arb <= 1'b0;
                        gnt         <= '0;
                        done        <= gnt;
                        err         <= !pready_s;
                        last        <= gidx;
                        state       <= IDLE;
                        if (!pready_s) begin
                            rdata <= '0;
                        end else if (!pwrite_mi) begin
                            rdata <= prdata_s;
                        end
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    else begin
                        to_cnt <= to_cnt + CW'(1);
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_arb.sv
module tb_apb_rr_arb;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned WW = 3;
    localparam int unsigned TO = 16;
`ifdef APB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_b;
    logic [N-1:0]    req;
    logic [N-1:0]    pwrite_m;
    logic [N*AW-1:0] paddr_m;
    logic [N*DW-1:0] pwdata_m;
    logic [N*WW-1:0] way_en_m;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [DW-1:0]   rdata;
    logic            err;
    logic            psel_arb;
    logic            penable_arb;
    logic            pwrite_mi;
    logic [AW-1:0]   paddr_mi;
    logic [DW-1:0]   pwdata_mi;
    logic [WW-1:0]   way_en;
    logic [DW-1:0]   prdata_s;
    logic            pready_s = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_rr_arb #(.N(N), .AW(AW), .DW(DW), .WW(WW), .TO_CYCLES(TO)) dut (
        .clk(clk), .rst_b(rst_b), .req(req), .pwrite_m(pwrite_m),
        .paddr_m(paddr_m), .pwdata_m(pwdata_m), .way_en_m(way_en_m),
        .gnt(gnt), .done(done), .rdata(rdata), .err(err),
        .psel_arb(psel_arb), .penable_arb(penable_arb), .pwrite_mi(pwrite_mi),
        .paddr_mi(paddr_mi), .pwdata_mi(pwdata_mi), .way_en(way_en),
        .prdata_s(prdata_s), .pready_s(pready_s)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // A transfer is a record (owner, start edge, latched fields); bus phases
    // follow from the distance between the current edge and the start edge.
    int            m_e = 0;
    bit            m_active = 1'b0;
    int            m_start = 0;
    int            m_owner = 0;
    int            m_last = N - 1;
    logic [N-1:0]  x_gnt, x_done;
    logic [DW-1:0] x_rdata;
    logic          x_err, x_psel, x_pen, x_pwrite;
    logic [AW-1:0] x_paddr;
    logic [DW-1:0] x_pwdata;
    logic [WW-1:0] x_way;

    always @(posedge clk) begin : model
        logic [N-1:0] elig;
        bit found, fin, tout;
        m_e = m_e + 1;
        if (!rst_b) begin
            m_active = 1'b0; m_last = N - 1;
            x_gnt = '0; x_done = '0; x_rdata = '0; x_err = 1'b0;
            x_psel = 1'b0; x_pen = 1'b0; x_pwrite = 1'b0;
            x_paddr = '0; x_pwdata = '0; x_way = '0;
        end else begin
            elig   = req & ~x_done;
            x_done = '0;
            if (m_active) begin
                fin  = 1'b0;
                tout = 1'b0;
                if (m_e == m_start + 1) x_pen = 1'b1;
                else if (pready_s) fin = 1'b1;
                else if (TO_EN && (m_e - m_start - 1 == int'(TO))) begin
                    fin = 1'b1; tout = 1'b1;
                end
                if (fin) begin
                    x_done[m_owner] = 1'b1;
                    x_gnt = '0; x_psel = 1'b0; x_pen = 1'b0;
                    x_err = tout;
                    if (tout) x_rdata = '0;
                    else if (!x_pwrite) x_rdata = prdata_s;
                    m_last = m_owner;
                    m_active = 1'b0;
                end
            end else begin
                found = 1'b0;
                for (int k = 1; k <= int'(N); k++) begin
                    if (!found && elig[(m_last + k) % N]) begin
                        found = 1'b1;
                        m_owner = (m_last + k) % N;
                    end
                end
                if (found) begin
                    m_active = 1'b1; m_start = m_e;
                    x_gnt = '0; x_gnt[m_owner] = 1'b1;
                    x_psel = 1'b1; x_pen = 1'b0;
                    x_pwrite = pwrite_m[m_owner];
                    x_paddr  = paddr_m[m_owner*AW +: AW];
                    x_pwdata = pwdata_m[m_owner*DW +: DW];
                    x_way    = way_en_m[m_owner*WW +: WW];
                end else begin
                    x_pwrite = 1'b0; x_paddr = '0; x_pwdata = '0; x_way = '0;
                end
            end
        end
    end

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_e >= 1) begin
            check("gnt", 64'(gnt), 64'(x_gnt));
            check("done", 64'(done), 64'(x_done));
            check("rdata", 64'(rdata), 64'(x_rdata));
            check("err", 64'(err), 64'(x_err));
            check("psel_arb", 64'(psel_arb), 64'(x_psel));
            check("penable_arb", 64'(penable_arb), 64'(x_pen));
            if (x_psel) begin
                check("pwrite_mi", 64'(pwrite_mi), 64'(x_pwrite));
                check("paddr_mi", 64'(paddr_mi), 64'(x_paddr));
                check("pwdata_mi", 64'(pwdata_mi), 64'(x_pwdata));
                check("way_en", 64'(way_en), 64'(x_way));
            end
        end
    end

    // si responder: pready_s after wait_cfg extra ACCESS cycles, or always when junk.
    int wait_cfg = 0;
    bit junk = 1'b0;
    always @(negedge clk) begin
        pready_s = junk || (m_active && (m_e + 1 - m_start - 2 == wait_cfg));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_master(input int i, input logic w, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [WW-1:0] we);
        pwrite_m[i]           = w;
        paddr_m[i*AW +: AW]   = a;
        pwdata_m[i*DW +: DW]  = d;
        way_en_m[i*WW +: WW]  = we;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int pen_cnt, cyc;
        int order[$];
        int exp_order[6];
        exp_order = '{0, 1, 2, 0, 1, 2};
        rst_b = 1'b0; req = 3'b111; prdata_s = 32'd3;
        pwrite_m = '0; paddr_m = '0; pwdata_m = '0; way_en_m = '0;
        set_master(0, 1'b1, 16'h0100, 32'h0000_0011, 3'b001);
        set_master(1, 1'b1, 16'h0010, 32'h0000_00A5, 3'b010);
        set_master(2, 1'b0, 16'h0020, 32'h0000_0000, 3'b100);

        // Reset with all requests active
        repeat (3) tick();
        check("reset_psel", 64'(psel_arb), 64'd0);
        check("reset_gnt", 64'(gnt), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        rst_b = 1'b1;
        tick();
        check("first_gnt", 64'(gnt), 64'b001);
        req = 3'b000;
        tick(); tick();
        check("m0_done", 64'(done), 64'b001);
        tick();

        // Single write from master 1, pready_s high even outside ACCESS
        junk = 1'b1; req = 3'b010;
        tick();
        check("wr_psel_k", 64'(psel_arb), 64'd1);
        check("wr_pen_k", 64'(penable_arb), 64'd0);
        check("wr_paddr", 64'(paddr_mi), 64'h0010);
        check("wr_pwdata", 64'(pwdata_mi), 64'h00A5);
        set_master(1, 1'b0, 16'hFFFF, 32'h0, 3'b111);
        tick();
        check("wr_pen_k1", 64'(penable_arb), 64'd1);
        check("wr_paddr_latched", 64'(paddr_mi), 64'h0010);
        tick();
        check("wr_done_k2", 64'(done), 64'b010);
        check("wr_err", 64'(err), 64'd0);
        check("wr_psel_k2", 64'(psel_arb), 64'd0);
        req = 3'b000; junk = 1'b0;
        tick();

        // Read from master 2 with three wait cycles
        wait_cfg = 3; req = 3'b100;
        tick();
        check("rd_psel", 64'(psel_arb), 64'd1);
        pen_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done != '0) break;
            if (penable_arb) pen_cnt++;
        end
        check("rd_pen_cycles", 64'(pen_cnt), 64'd4);
        check("rd_done", 64'(done), 64'b100);
        check("rd_rdata", 64'(rdata), 64'd3);
        req = 3'b000;
        tick();
        check("rd_done_pulse", 64'(done), 64'd0);

        // Round robin with all masters requesting
        set_master(1, 1'b1, 16'h0010, 32'h0000_00A5, 3'b010);
        prdata_s = 32'hDEAD_BEEF; wait_cfg = 0; req = 3'b111;
        for (int i = 0; i < 60 && order.size() < 6; i++) begin
            tick();
            if (psel_arb && !penable_arb)
                for (int j = 0; j < int'(N); j++) if (gnt[j]) order.push_back(j);
        end
        req = 3'b000;
        for (int i = 0; i < 10; i++) begin tick(); if (done != '0) break; end
        tick();
        check("rr_count", 64'(order.size()), 64'd6);
        for (int i = 0; i < 6 && i < order.size(); i++)
            check($sformatf("rr_order%0d", i), 64'(order[i]), 64'(exp_order[i]));

        // Master 0 completes, then reset aborts master 1 mid-ACCESS
        req = 3'b001;
        for (int i = 0; i < 10; i++) begin tick(); if (done != '0) break; end
        req = 3'b000;
        tick();
        wait_cfg = 5; req = 3'b010;
        tick(); tick(); tick();
        check("mid_in_access", 64'({psel_arb, penable_arb}), 64'b11);
        rst_b = 1'b0;
        tick();
        check("mid_rst_bus", 64'({psel_arb, penable_arb}), 64'b00);
        check("mid_rst_gnt", 64'(gnt), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        tick();
        check("mid_rst_done2", 64'(done), 64'd0);
        rst_b = 1'b1; wait_cfg = 0; req = 3'b111;
        tick();
        check("post_rst_gnt", 64'(gnt), 64'b001);
        req = 3'b000;
        repeat (3) tick();

        // Prime rdata with a read, then a transfer with no slave selected
        req = 3'b100;
        for (int i = 0; i < 10; i++) begin tick(); if (done != '0) break; end
        req = 3'b000;
        tick();
        check("prime_rdata", 64'(rdata), 64'hDEAD_BEEF);
        set_master(1, 1'b0, 16'h0044, 32'h0, 3'b000);
        wait_cfg = 1000; req = 3'b010;
        tick();
        check("to_way_zero", 64'(way_en), 64'd0);
`ifdef APB_ARB_TIMEOUT_EN
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            tick(); cyc++;
            if (done != '0) break;
        end
        check("to_cycles", 64'(cyc), 64'd17);
        check("to_done", 64'(done), 64'b010);
        check("to_err", 64'(err), 64'd1);
        check("to_rdata", 64'(rdata), 64'd0);
        req = 3'b000;
        tick();
`else
        cyc = 0;
        repeat (30) begin tick(); cyc++; end
        check("hang_bus", 64'({psel_arb, penable_arb}), 64'b11);
        check("hang_done", 64'(done), 64'd0);
        check("hang_err", 64'(err), 64'd0);
        rst_b = 1'b0; req = 3'b000;
        tick();
        rst_b = 1'b1;
        tick();
`endif
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
